// File: rtl/kyber_pkg.sv
// Shared Kyber constants, adder mode encodings and the poly_add_seq state type.
// Also hosts the conditional-subtract reduction used by the modular adder.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;
  localparam int KYBER_N = 256;

  localparam logic [12:0] Q13 = 13'd3329;

  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pas_state_e;

  // Inputs are a sum of two operands below q, so one subtraction suffices.
  function automatic logic [COEF_W-1:0] cond_sub_q(input logic [COEF_W:0] s);
    logic [COEF_W:0] t;
    t = s - Q13;
    if (s >= Q13) begin
      return t[COEF_W-1:0];
    end else begin
      return s[COEF_W-1:0];
    end
  endfunction

endpackage

// File: rtl/poly_add_seq_if.sv
// Control, read-port and write-port bundle of the polynomial add sequencer.
// The slave modport is the sequencer; the master side is the controller plus RAMs.
interface poly_add_seq_if #(parameter int AW = 8);

  logic                         start;
  logic [1:0]                   mode;
  logic                         busy;
  logic                         done;
  logic                         rd_en;
  logic [AW-1:0]                rd_addr;
  logic [kyber_pkg::COEF_W-1:0] rd_data_a;
  logic [kyber_pkg::COEF_W-1:0] rd_data_b;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [kyber_pkg::COEF_W-1:0] wr_data;

  modport master (
    output start, mode, rd_data_a, rd_data_b,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, mode, rd_data_a, rd_data_b,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/poly_add_seq_add.sv
// Combinational modular adder mod q with optional halving (multiply by 2^-1 mod q).
// Operands must already be reduced below q.
module add
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  input  logic              half_i,
  output logic [COEF_W-1:0] y_o
);

  logic [COEF_W:0]   sum_s;
  logic [COEF_W-1:0] red_s;
  logic [COEF_W:0]   odd_s;

  // Reduce the sum, then halve; an odd residue is made even by adding q first.
  always_comb begin
    sum_s = {1'b0, a_i} + {1'b0, b_i};
    red_s = cond_sub_q(sum_s);
    odd_s = {1'b0, red_s} + Q13;
    if (!half_i) begin
      y_o = red_s;
    end else if (red_s[0]) begin
      y_o = odd_s[COEF_W:1];
    end else begin
      y_o = {1'b0, red_s[COEF_W-1:1]};
    end
  end

endmodule

// File: rtl/poly_add_seq.sv
// Streams N coefficient pairs through the modular adder and writes the results
// with a fixed two-stage pipeline: read issue, adder/register, write.
module poly_add_seq
  import kyber_pkg::*;
#(
  parameter int N  = KYBER_N,
  parameter int AW = 8
) (
  input logic           clk,
  input logic           rst,
  poly_add_seq_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  pas_state_e        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic [1:0]        mode_q, mode_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     a1_q, a1_d;
  logic              v1_q, v1_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [COEF_W-1:0] wr_data_q, wr_data_d;
  logic [COEF_W-1:0] add_y_s;

  add u_add (
    .a_i    (bus.rd_data_a),
    .b_i    (bus.rd_data_b),
    .half_i (mode_q == MODE_HALF),
    .y_o    (add_y_s)
  );

  // Next-state logic; strobes are derived from the next state so they leave flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    mode_d    = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mode_d  = bus.mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);

    a1_d    = cnt_q;
    v1_d    = rd_en_q;
    wr_en_d = v1_q;
    if (v1_q) begin
      wr_addr_d = a1_q;
      wr_data_d = add_y_s;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // State, counter, stage-1 and stage-2 registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      mode_q    <= MODE_ADD;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a1_q      <= '0;
      v1_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      mode_q    <= mode_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a1_q      <= a1_d;
      v1_q      <= v1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = cnt_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_add_seq.sv
// Directed bench for poly_add_seq: vector table of constant-operand runs plus
// hand-built sequences for ramp data, busy lockout, mid-run reset and back-to-back.
module tb_poly_add_seq;
  import kyber_pkg::*;

  localparam int N     = 256;
  localparam int AW    = 8;
  localparam int LOGSZ = 600;

  typedef struct {
    logic [1:0]  md;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_add_seq_if #(.AW(AW)) bus();
  poly_add_seq #(.N(N), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [11:0] mem_a [N];
  logic [11:0] mem_b [N];
  logic [11:0] exp_mem [N];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem_a[bus.rd_addr];
      bus.rd_data_b <= mem_b[bus.rd_addr];
    end
  end

  logic        lg_we [LOGSZ];
  logic        lg_done [LOGSZ];
  logic        lg_busy [LOGSZ];
  logic        lg_re [LOGSZ];
  logic [7:0]  lg_wa [LOGSZ];
  logic [7:0]  lg_ra [LOGSZ];
  logic [11:0] lg_wd [LOGSZ];

  int n_vec = 0;
  int n_err = 0;
  vec_t vt [14];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"},    int'(bus.busy),    0);
    chk({nm, "_done"},    int'(bus.done),    0);
    chk({nm, "_rd_en"},   int'(bus.rd_en),   0);
    chk({nm, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({nm, "_wr_en"},   int'(bus.wr_en),   0);
    chk({nm, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({nm, "_wr_data"}, int'(bus.wr_data), 0);
  endtask

  function automatic logic [11:0] model(input logic [1:0] md, input int a, input int b);
    if (md == 2'd1) return 12'(((a + b) * 1665) % 3329);
    else            return 12'((a + b) % 3329);
  endfunction

  // Start an operation, then log outputs for cycles 1..lim relative to start.
  task automatic run_op(input logic [1:0] md, input int pulse_cyc, input logic [1:0] pulse_md,
                        input int rst_cyc, input int lim);
    @(negedge clk);
    bus.mode  = md;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = md ^ 2'b01;
    for (int k = 1; k <= lim; k++) begin
      lg_we[k] = bus.wr_en;   lg_done[k] = bus.done; lg_busy[k] = bus.busy;
      lg_re[k] = bus.rd_en;   lg_wa[k]   = bus.wr_addr;
      lg_ra[k] = bus.rd_addr; lg_wd[k]   = bus.wr_data;
      if (k == pulse_cyc) begin
        bus.start = 1'b1;
        bus.mode  = pulse_md;
      end
      if (k == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk("wr_en_drop_on_rst", int'(bus.wr_en), 0);
        chk("done_on_rst", int'(bus.done), 0);
      end
      if (rst_cyc > 0 && k == rst_cyc + 2) rst = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  // Compare the logged run against the cycle-exact timing and exp_mem contents.
  task automatic check_op(input string nm, input int op2, input int rst_cyc, input int lim,
                          input int exp_writes);
    int bad_we = 0, bad_done = 0, bad_busy = 0, bad_re = 0;
    int bad_ra = 0, bad_wa = 0, bad_wd = 0, n_wr = 0;
    for (int k = 1; k <= lim; k++) begin
      logic e_we, e_done, e_busy, e_re, c_ra, c_wa;
      int e_ra, e_wa;
      e_we = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_re = 1'b0;
      c_ra = 1'b0; c_wa = 1'b0; e_ra = 0; e_wa = 0;
      for (int o = 0; o < 2; o++) begin
        int r;
        r = (o == 0) ? k : k - op2;
        if (o == 0 || op2 > 0) begin
          if (r >= 3 && r <= N + 2) begin e_we = 1'b1; c_wa = 1'b1; e_wa = r - 3; end
          if (r >= 1 && r <= N)     begin e_re = 1'b1; c_ra = 1'b1; e_ra = r - 1; end
          if (r >= 1 && r <= N + 2) e_busy = 1'b1;
          if (r == N + 3)           e_done = 1'b1;
        end
      end
      if (rst_cyc > 0 && k > rst_cyc) begin
        e_we = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_re = 1'b0;
        c_ra = 1'b1; c_wa = 1'b1; e_ra = 0; e_wa = 0;
        if (lg_wd[k] !== 12'd0) bad_wd++;
      end
      if (lg_we[k] !== e_we)     bad_we++;
      if (lg_done[k] !== e_done) bad_done++;
      if (lg_busy[k] !== e_busy) bad_busy++;
      if (lg_re[k] !== e_re)     bad_re++;
      if (c_ra && int'(lg_ra[k]) != e_ra) bad_ra++;
      if (c_wa && int'(lg_wa[k]) != e_wa) bad_wa++;
      if (lg_we[k] === 1'b1) begin
        n_wr++;
        if (lg_wd[k] !== exp_mem[lg_wa[k]]) bad_wd++;
      end
    end
    chk({nm, "_wr_en_cycles"},  bad_we,   0);
    chk({nm, "_done_cycles"},   bad_done, 0);
    chk({nm, "_busy_cycles"},   bad_busy, 0);
    chk({nm, "_rd_en_cycles"},  bad_re,   0);
    chk({nm, "_rd_addr_seq"},   bad_ra,   0);
    chk({nm, "_wr_addr_seq"},   bad_wa,   0);
    chk({nm, "_wr_data"},       bad_wd,   0);
    chk({nm, "_write_count"},   n_wr,     exp_writes);
  endtask

  task automatic load_ramp(input logic [1:0] md);
    for (int i = 0; i < N; i++) begin
      mem_a[i]   = 12'd3328;
      mem_b[i]   = 12'(i);
      exp_mem[i] = model(md, 3328, i);
    end
  endtask

  initial begin
    vt[0]  = '{2'd0, 12'd3328, 12'd0,    12'd3328};
    vt[1]  = '{2'd0, 12'd3328, 12'd1,    12'd0};
    vt[2]  = '{2'd0, 12'd3328, 12'd255,  12'd254};
    vt[3]  = '{2'd0, 12'd0,    12'd0,    12'd0};
    vt[4]  = '{2'd0, 12'd1664, 12'd1665, 12'd0};
    vt[5]  = '{2'd0, 12'd1000, 12'd2000, 12'd3000};
    vt[6]  = '{2'd0, 12'd3000, 12'd3000, 12'd2671};
    vt[7]  = '{2'd1, 12'd1,    12'd0,    12'd1665};
    vt[8]  = '{2'd1, 12'd2,    12'd2,    12'd2};
    vt[9]  = '{2'd1, 12'd3328, 12'd3328, 12'd3328};
    vt[10] = '{2'd1, 12'd3328, 12'd0,    12'd1664};
    vt[11] = '{2'd1, 12'd3,    12'd0,    12'd1666};
    vt[12] = '{2'd2, 12'd3328, 12'd2,    12'd1};
    vt[13] = '{2'd3, 12'd5,    12'd6,    12'd11};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 1);
      chk_zero_outputs("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_reset_busy", int'(bus.busy), 0);
      chk("post_reset_rd_en", int'(bus.rd_en), 0);
    end

    foreach (vt[v]) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] = vt[v].a; mem_b[i] = vt[v].b; exp_mem[i] = vt[v].y;
      end
      run_op(vt[v].md, 0, 2'd0, 0, N + 6);
      check_op($sformatf("vec%0d", v), 0, 0, N + 6, N);
    end

    load_ramp(2'd0);
    run_op(2'd0, 10, 2'd1, 0, N + 8);
    check_op("ramp_lockout", 0, 0, N + 8, N);
    chk("ramp_wd0",   int'(lg_wd[3]),   3328);
    chk("ramp_wd1",   int'(lg_wd[4]),   0);
    chk("ramp_wd255", int'(lg_wd[258]), 254);
    chk("ramp_done_259", int'(lg_done[N + 3]), 1);

    for (int i = 0; i < N; i++) begin
      mem_a[i]   = 12'($urandom_range(0, 3328));
      mem_b[i]   = 12'($urandom_range(0, 3328));
      exp_mem[i] = model(2'd1, int'(mem_a[i]), int'(mem_b[i]));
    end
    run_op(2'd1, 0, 2'd0, 0, N + 6);
    check_op("rand_half", 0, 0, N + 6, N);

    load_ramp(2'd0);
    run_op(2'd0, 0, 2'd0, 100, N + 6);
    check_op("rst_mid", 0, 100, N + 6, 98);
    run_op(2'd0, 0, 2'd0, 0, N + 6);
    check_op("after_rst", 0, 0, N + 6, N);

    load_ramp(2'd1);
    run_op(2'd1, N + 4, 2'd1, 0, 2 * N + 10);
    check_op("b2b", N + 4, 0, 2 * N + 10, 2 * N);
    chk("b2b_first_write2", int'(lg_we[N + 7]), 1);
    chk("b2b_gap_before2",  int'(lg_we[N + 6]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
